// File: rtl/pio_in_debounced.sv
// Avalon-MM input PIO: per-bit 2-flop synchroniser, debounce filter, edge capture,
// per-bit interrupt mask and a level IRQ output.

module pio_in_debounced_lane #(
    parameter int DEBOUNCE  = 50000,
    parameter int EDGE_TYPE = 0,
    parameter int CW        = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_sync,
    output logic o_stable,
    output logic o_set
);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

    logic [CW-1:0] r_cnt;
    logic          r_stable;
    logic          w_accept;
    logic          w_match;

    // A new level is accepted only after it has differed from the stable
    // level for DEBOUNCE consecutive clocks; any return restarts the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else if (i_sync == r_stable) begin
            r_cnt    <= '0;
        end else if (r_cnt == LAST) begin
            r_stable <= i_sync;
            r_cnt    <= '0;
        end else begin
            r_cnt    <= r_cnt + 1'b1;
        end
    end

    assign w_accept = (i_sync != r_stable) && (r_cnt == LAST);
    assign w_match  = (EDGE_TYPE == 2) ||
                      (EDGE_TYPE == 0 &&  i_sync) ||
                      (EDGE_TYPE == 1 && !i_sync);
    assign o_set    = w_accept && w_match;
    assign o_stable = r_stable;
endmodule

module pio_in_debounced #(
    parameter int WIDTH     = 4,
    parameter int DEBOUNCE  = 50000,
    parameter int EDGE_TYPE = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);
    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_edge;
    logic [31:0]      r_readdata;

    logic [WIDTH-1:0] w_stable;
    logic [WIDTH-1:0] w_set;
    logic [WIDTH-1:0] w_clr;
    logic             w_wr;
    logic [31:0]      w_rd;
    logic             w_unused;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= in_port;
            r_s2 <= r_s1;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        pio_in_debounced_lane #(
            .DEBOUNCE  (DEBOUNCE),
            .EDGE_TYPE (EDGE_TYPE),
            .CW        (CW)
        ) u_lane (
            .clk      (clk),
            .reset_n  (reset_n),
            .i_sync   (r_s2[i]),
            .o_stable (w_stable[i]),
            .o_set    (w_set[i])
        );
    end

    assign w_wr  = chipselect && !write_n;
    assign w_clr = (w_wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    // A capture in the same clock as a W1C of that bit wins over the clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mask <= '0;
            r_edge <= '0;
        end else begin
            if (w_wr && address == 2'd2)
                r_mask <= writedata[WIDTH-1:0];
            r_edge <= (r_edge & ~w_clr) | w_set;
        end
    end

    always_comb begin
        w_rd = '0;
        case (address)
            2'd0:    w_rd[WIDTH-1:0] = w_stable;
            2'd2:    w_rd[WIDTH-1:0] = r_mask;
            2'd3:    w_rd[WIDTH-1:0] = r_edge;
            default: w_rd = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_readdata <= '0;
        else
            r_readdata <= w_rd;
    end

    assign readdata = r_readdata;
    assign irq      = |(r_edge & r_mask);
    assign w_unused = &{1'b0, writedata};
endmodule

// File: tb/tb_pio_in_debounced.sv
// Directed bench for pio_in_debounced: two instances (rising and falling capture)
// share the bus; expectations go into a scoreboard drained by a monitor.

module tb_pio_in_debounced;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port, in_port_f;
    logic [31:0] readdata, readdata_f;
    logic        irq, irq_f;

    always #5 clk = ~clk;

    pio_in_debounced #(.WIDTH(4), .DEBOUNCE(4), .EDGE_TYPE(0)) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    pio_in_debounced #(.WIDTH(4), .DEBOUNCE(4), .EDGE_TYPE(1)) u_dut_f (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata_f),
        .in_port    (in_port_f),
        .irq        (irq_f)
    );

    // kind: 0 readdata, 1 readdata_f, 2 irq, 3 irq_f
    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
        int          due;
    } item_t;

    item_t       sb[$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    bit          end_chk = 1'b0;
    bit          mon_done = 1'b0;
    event        chk_now;
    item_t       mon_it;
    logic [31:0] mon_act;

    always @(posedge clk) cyc <= cyc + 1;

    always begin
        @(negedge clk or chk_now);
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            mon_it = sb.pop_front();
            case (mon_it.kind)
                0:       mon_act = readdata;
                1:       mon_act = readdata_f;
                2:       mon_act = {31'd0, irq};
                default: mon_act = {31'd0, irq_f};
            endcase
            n_cmp++;
            if (mon_act !== mon_it.exp) begin
                n_err++;
                $display("FAIL %s: got %h, expected %h", mon_it.name, mon_act, mon_it.exp);
            end
        end
        if (end_chk && !mon_done) begin
            n_cmp++;
            if (sb.size() != 0) begin
                n_err++;
                $display("FAIL sb_drain: got %0d pending, expected 0", sb.size());
            end
            mon_done = 1'b1;
        end
    end

    task automatic push(input int kind, input logic [31:0] exp, input string name, input int due);
        item_t it;
        it.kind = kind;
        it.exp  = exp;
        it.name = name;
        it.due  = due;
        sb.push_back(it);
    endtask

    // Expectation sampled at the negedge following the next posedge.
    task automatic expect_nxt(input int kind, input logic [31:0] exp, input string name);
        push(kind, exp, name, cyc + 1);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic rd(input logic [1:0] a, input int kind, input logic [31:0] exp, input string name);
        address = a;
        expect_nxt(kind, exp, name);
        step();
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
        in_port    = 4'h0;
        in_port_f  = 4'h0;

        @(negedge clk);
        @(negedge clk);
        #1;
        push(0, 32'h0, "init_rdata", cyc);
        push(2, 32'h0, "init_irq", cyc);
        -> chk_now;
        @(negedge clk);
        reset_n = 1'b1;

        rd(2'd2, 0, 32'h0, "init_mask");
        rd(2'd3, 0, 32'h0, "init_edge");
        rd(2'd0, 0, 32'h0, "init_data");

        // Latency: sampled into s1 at edge k, visible on readdata at edge k+6.
        address = 2'd0;
        in_port = 4'h1;
        for (int i = 0; i < 7; i++)
            rd(2'd0, 0, (i == 6) ? 32'h1 : 32'h0, "lat_data");
        rd(2'd3, 0, 32'h1, "lat_edge");

        // Three-clock glitch on bit 1 is discarded.
        in_port = 4'h3;
        idle(3);
        in_port = 4'h1;
        idle(6);
        rd(2'd0, 0, 32'h1, "glitch_data");
        rd(2'd3, 0, 32'h1, "glitch_edge");

        // Four clocks is enough.
        in_port = 4'h3;
        idle(7);
        rd(2'd0, 0, 32'h3, "long_data");
        rd(2'd3, 0, 32'h3, "long_edge");

        // Mask / irq / W1C.
        wr(2'd3, 32'h3);
        wr(2'd2, 32'hFFFF_FFF2);
        expect_nxt(2, 32'h0, "irq_off");
        rd(2'd2, 0, 32'h2, "mask_wr");
        rd(2'd3, 0, 32'h0, "edge_clr");
        in_port = 4'h1;
        idle(7);
        expect_nxt(2, 32'h0, "irq_fall");
        rd(2'd3, 0, 32'h0, "fall_nocap");
        in_port = 4'h3;
        idle(7);
        expect_nxt(2, 32'h1, "irq_set");
        rd(2'd3, 0, 32'h2, "edge_b1");
        expect_nxt(2, 32'h0, "irq_clr");
        wr(2'd3, 32'h2);
        rd(2'd3, 0, 32'h0, "edge_w1c");

        // Accept on bit 0 coincides with W1C of bit 0.
        in_port = 4'h2;
        idle(7);
        in_port = 4'h3;
        idle(5);
        wr(2'd3, 32'h1);
        rd(2'd3, 0, 32'h1, "set_over_clr");
        wr(2'd3, 32'h1);
        rd(2'd3, 0, 32'h0, "w1c_later");

        // Falling-edge instance.
        in_port_f = 4'hF;
        idle(7);
        rd(2'd0, 1, 32'hF, "f_data_hi");
        rd(2'd3, 1, 32'h0, "f_no_rise");
        in_port_f = 4'h0;
        idle(7);
        expect_nxt(3, 32'h1, "f_irq");
        rd(2'd3, 1, 32'hF, "f_edge");

        // Reset mid-debounce.
        wr(2'd2, 32'hF);
        in_port = 4'h0;
        idle(3);
        address = 2'd2;
        expect_nxt(0, 32'hF, "mask_F");
        expect_nxt(3, 32'h1, "f_irq_pre");
        step();
        #1;
        reset_n = 1'b0;
        #1;
        push(0, 32'h0, "rst_rdata", cyc);
        push(1, 32'h0, "rst_rdata_f", cyc);
        push(2, 32'h0, "rst_irq", cyc);
        push(3, 32'h0, "rst_irq_f", cyc);
        -> chk_now;
        @(negedge clk);
        reset_n = 1'b1;
        rd(2'd2, 0, 32'h0, "mask_rst");
        rd(2'd3, 0, 32'h0, "edge_rst");
        rd(2'd0, 0, 32'h0, "data_rst");
        rd(2'd3, 1, 32'h0, "f_edge_rst");

        // DATA and RSVD ignore writes.
        in_port = 4'h5;
        idle(7);
        rd(2'd0, 0, 32'h5, "data5");
        wr(2'd0, 32'hA);
        wr(2'd1, 32'hFFFF_FFFF);
        rd(2'd0, 0, 32'h5, "data_ro");
        rd(2'd1, 0, 32'h0, "rsvd");
        rd(2'd3, 0, 32'h5, "edge_post");

        idle(2);
        #1;
        end_chk = 1'b1;
        -> chk_now;
        wait (mon_done);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
